alu_op_sequencer: RTL and testbench

Clocked command front-end that sits directly upstream of the combinational BreadBoard ALU (IN1/IN2/OP -> OUT/ERR).
- Accepts one operation at a time over a valid/ready command interface.
- Holds the operands stable on the ALU inputs for a programmable settle window, then captures OUT/ERR into a result register.
- Presents the captured result downstream over a valid/ready interface.
- Gives the purely combinational datapath a registered, back-pressurable boundary.

---
 rtl/alu_op_sequencer.sv | 177 +++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Clocked command front-end for the combinational BreadBoard ALU. Takes one
// operation at a time, holds the operands on the ALU inputs for a settle
// window, captures OUT/ERR and presents the result over valid/ready.
//
// Optional feature (compile-time macro): ALU_ACC_EN
//   Adds a 32-bit accumulator, loaded on every clean result handshake
//   (RES_ILL=0, RES_ERR=00). A command with CMD_ACC=1 then sources ALU_IN1
//   from accumulator[15:0]. Without the macro CMD_ACC is ignored.
//
// Ports:
//   CLK, RST                 clock, synchronous active-high reset
//   CMD_VALID/CMD_READY      command handshake
//   CMD_IN1/IN2/OP/ACC       command payload
//   ALU_IN1/IN2/OP           registered drive to the ALU
//   ALU_OUT/ALU_ERR          ALU result (err bit0 overflow, bit1 div/mod by 0)
//   RES_VALID/RES_READY      result handshake
//   RES_OUT/ERR/ILL/OP       captured result, error, illegal flag, opcode
//   BUSY                     high while in SETTLE or HOLD
//   OP_CNT                   completed result handshakes (wraps)
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
   parameter int SETTLE_CYCLES = 4,
   parameter int MAX_OP        = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        CMD_VALID,
   output logic        CMD_READY,
   input  logic [15:0] CMD_IN1,
   input  logic [15:0] CMD_IN2,
   input  logic [3:0]  CMD_OP,
   input  logic        CMD_ACC,
   output logic [15:0] ALU_IN1,
   output logic [15:0] ALU_IN2,
   output logic [3:0]  ALU_OP,
   input  logic [31:0] ALU_OUT,
   input  logic [1:0]  ALU_ERR,
   output logic        RES_VALID,
   input  logic        RES_READY,
   output logic [31:0] RES_OUT,
   output logic [1:0]  RES_ERR,
   output logic        RES_ILL,
   output logic [3:0]  RES_OP,
   output logic        BUSY,
   output logic [15:0] OP_CNT
);

   localparam logic [7:0] CNT_INIT = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] OP_LIMIT = 4'(MAX_OP);

   typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;

   state_t      state, state_nxt;
   logic [7:0]  cnt;
   logic        accept;
   logic        illegal;
   logic        res_hs;
   logic [15:0] op1_sel;

   assign accept  = CMD_READY && CMD_VALID;
   assign illegal = CMD_OP > OP_LIMIT;
   assign res_hs  = RES_VALID && RES_READY;

`ifdef ALU_ACC_EN
   logic [31:0] acc;
   logic        unused_acc_hi;

   // Only the low half feeds the 16-bit ALU port; the full width is kept
   // so a later readout sees the whole previous result.
   assign unused_acc_hi = ^acc[31:16];
   assign op1_sel       = CMD_ACC ? acc[15:0] : CMD_IN1;

   always_ff @(posedge CLK) begin
      if (RST)
         acc <= '0;
      else if (res_hs && !RES_ILL && (RES_ERR == 2'b00))
         acc <= RES_OUT;
   end
`else
   logic unused_acc;

   assign unused_acc = CMD_ACC;
   assign op1_sel    = CMD_IN1;
`endif

   // state register
   always_ff @(posedge CLK) begin
      if (RST)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = illegal ? HOLD : SETTLE;
         SETTLE:  if (cnt == 8'd0) state_nxt = HOLD;
         HOLD:    if (res_hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // state-decoded outputs
   always_comb begin
      CMD_READY = 1'b0;
      BUSY      = 1'b0;
      case (state)
         IDLE:    CMD_READY = 1'b1;
         SETTLE:  BUSY      = 1'b1;
         HOLD:    BUSY      = 1'b1;
         default: ;
      endcase
   end

   // datapath: operand latch, settle counter, result capture, handshake count
   always_ff @(posedge CLK) begin
      if (RST) begin
         ALU_IN1   <= '0;
         ALU_IN2   <= '0;
         ALU_OP    <= '0;
         cnt       <= '0;
         RES_OUT   <= '0;
         RES_ERR   <= '0;
         RES_ILL   <= 1'b0;
         RES_OP    <= '0;
         RES_VALID <= 1'b0;
         OP_CNT    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  ALU_IN1 <= op1_sel;
                  ALU_IN2 <= CMD_IN2;
                  ALU_OP  <= CMD_OP;
                  if (illegal) begin
                     // Result fields are final at accept; RES_VALID follows
                     // one edge later from HOLD so the illegal result keeps
                     // the one-cycle accept-to-valid latency.
                     RES_OUT <= '0;
                     RES_ERR <= '0;
                     RES_ILL <= 1'b1;
                     RES_OP  <= CMD_OP;
                  end else begin
                     cnt <= CNT_INIT;
                  end
               end
            end
            SETTLE: begin
               if (cnt == 8'd0) begin
                  RES_OUT   <= ALU_OUT;
                  RES_ERR   <= ALU_ERR;
                  RES_ILL   <= 1'b0;
                  RES_OP    <= ALU_OP;
                  RES_VALID <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            HOLD: begin
               if (!RES_VALID) begin
                  RES_VALID <= 1'b1;
               end else if (RES_READY) begin
                  RES_VALID <= 1'b0;
                  OP_CNT    <= OP_CNT + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Directed plus randomized bench for alu_op_sequencer. The bench plays the
// combinational ALU itself and predicts every result from the command
// operands with plain arithmetic, tracking the handshake count and (when
// ALU_ACC_EN is defined) the accumulator as simple variables.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

   localparam int SC  = 4;
   localparam int MOP = 4;

   logic        CLK = 1'b0;
   logic        RST;
   logic        CMD_VALID, CMD_READY;
   logic [15:0] CMD_IN1, CMD_IN2;
   logic [3:0]  CMD_OP;
   logic        CMD_ACC;
   logic [15:0] ALU_IN1, ALU_IN2;
   logic [3:0]  ALU_OP;
   logic [31:0] ALU_OUT;
   logic [1:0]  ALU_ERR;
   logic        RES_VALID, RES_READY;
   logic [31:0] RES_OUT;
   logic [1:0]  RES_ERR;
   logic        RES_ILL;
   logic [3:0]  RES_OP;
   logic        BUSY;
   logic [15:0] OP_CNT;

   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] exp_cnt;
   logic [31:0] m_acc;

   alu_op_sequencer #(.SETTLE_CYCLES(SC), .MAX_OP(MOP)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
      .CMD_IN1(CMD_IN1), .CMD_IN2(CMD_IN2), .CMD_OP(CMD_OP), .CMD_ACC(CMD_ACC),
      .ALU_IN1(ALU_IN1), .ALU_IN2(ALU_IN2), .ALU_OP(ALU_OP),
      .ALU_OUT(ALU_OUT), .ALU_ERR(ALU_ERR),
      .RES_VALID(RES_VALID), .RES_READY(RES_READY),
      .RES_OUT(RES_OUT), .RES_ERR(RES_ERR), .RES_ILL(RES_ILL), .RES_OP(RES_OP),
      .BUSY(BUSY), .OP_CNT(OP_CNT)
   );

   always #5 CLK = ~CLK;

   // ALU behaviour: {err, out}. err bit0 overflow/underflow, bit1 div by zero.
   function automatic logic [33:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [3:0] op);
      logic [31:0] r;
      logic [1:0]  e;
      r = '0;
      e = '0;
      case (op)
         4'd0: begin r = 32'(a) + 32'(b); e[0] = r > 32'hFFFF; end
         4'd1: begin r = 32'(a) - 32'(b); e[0] = a < b; end
         4'd2: begin r = 32'(a) * 32'(b); e[0] = r > 32'hFFFF; end
         4'd3: if (b == 16'd0) e = 2'b10; else r = 32'(a / b);
         4'd4: if (b == 16'd0) e = 2'b10; else r = 32'(a % b);
         default: ;
      endcase
      return {e, r};
   endfunction

   always_comb {ALU_ERR, ALU_OUT} = alu_fn(ALU_IN1, ALU_IN2, ALU_OP);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One full command: accept, wait for result, optional back-pressure with
   // a competing command, then the result handshake.
   task automatic run_op(input logic [15:0] in1, input logic [15:0] in2,
                         input logic [3:0] op, input logic acc, input int hold);
      logic [15:0] e_in1;
      logic [33:0] r;
      logic        ill;
      logic [31:0] e_out;
      logic [1:0]  e_err;
      int          lat;
      e_in1 = in1;
`ifdef ALU_ACC_EN
      if (acc) e_in1 = m_acc[15:0];
`endif
      ill   = op > 4'(MOP);
      r     = alu_fn(e_in1, in2, op);
      e_out = ill ? 32'd0 : r[31:0];
      e_err = ill ? 2'b00 : r[33:32];

      chk("idle_cmd_ready", 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b1; CMD_IN1 = in1; CMD_IN2 = in2; CMD_OP = op; CMD_ACC = acc;
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      chk("accept_busy", 32'(BUSY), 32'd1);
      chk("alu_in1", 32'(ALU_IN1), 32'(e_in1));
      chk("alu_in2", 32'(ALU_IN2), 32'(in2));
      chk("alu_op", 32'(ALU_OP), 32'(op));

      lat = 0;
      while (!RES_VALID && lat < 300) begin
         @(posedge CLK); #1;
         lat++;
      end
      chk("latency", 32'(lat), ill ? 32'd1 : 32'(SC));
      chk("res_out", RES_OUT, e_out);
      chk("res_err", 32'(RES_ERR), 32'(e_err));
      chk("res_ill", 32'(RES_ILL), 32'(ill));
      chk("res_op", 32'(RES_OP), 32'(op));

      for (int i = 0; i < hold; i++) begin
         CMD_VALID = 1'b1; CMD_IN1 = ~in1; CMD_IN2 = ~in2; CMD_OP = op ^ 4'h1;
         @(posedge CLK); #1;
         chk("bp_res_valid", 32'(RES_VALID), 32'd1);
         chk("bp_res_out", RES_OUT, e_out);
         chk("bp_cmd_ready", 32'(CMD_READY), 32'd0);
         chk("bp_alu_in1", 32'(ALU_IN1), 32'(e_in1));
      end

      CMD_VALID = 1'b0;
      RES_READY = 1'b1;
      @(posedge CLK); #1;
      RES_READY = 1'b0;
      exp_cnt = exp_cnt + 16'd1;
      if (!ill && e_err == 2'b00) m_acc = e_out;
      chk("hs_res_valid", 32'(RES_VALID), 32'd0);
      chk("op_cnt", 32'(OP_CNT), 32'(exp_cnt));
      chk("hs_cmd_ready", 32'(CMD_READY), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0]  rop;
      logic [15:0] rin2;
      RST = 1'b1; CMD_VALID = 1'b0; CMD_IN1 = '0; CMD_IN2 = '0; CMD_OP = '0;
      CMD_ACC = 1'b0; RES_READY = 1'b0;
      exp_cnt = '0; m_acc = '0;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // reset state
      chk("rst_cmd_ready", 32'(CMD_READY), 32'd1);
      chk("rst_busy", 32'(BUSY), 32'd0);
      chk("rst_res_valid", 32'(RES_VALID), 32'd0);
      chk("rst_op_cnt", 32'(OP_CNT), 32'd0);
      chk("rst_alu_in1", 32'(ALU_IN1), 32'd0);
      chk("rst_res_out", RES_OUT, 32'd0);

      // directed operations
      run_op(16'd11, 16'd51, 4'd0, 1'b0, 0);   // 62
      run_op(16'd11, 16'd51, 4'd1, 1'b0, 0);   // FFFFFFD8, err 01
      run_op(16'd11, 16'd51, 4'd2, 1'b0, 0);   // 561
      run_op(16'd11, 16'd0,  4'd3, 1'b0, 0);   // div by zero
      run_op(16'd11, 16'd51, 4'd7, 1'b0, 0);   // illegal opcode
      run_op(16'd11, 16'd51, 4'd2, 1'b0, 10);  // back-pressure, competing cmd
      run_op(16'd11, 16'd51, 4'd0, 1'b0, 0);   // accumulator <- 62
      run_op(16'd100, 16'd5, 4'd0, 1'b1, 0);   // 67 with acc, 105 without

      // reset during SETTLE abandons the command
      CMD_VALID = 1'b1; CMD_IN1 = 16'd62091; CMD_IN2 = 16'd47411; CMD_OP = 4'd0;
      CMD_ACC = 1'b0;
      @(posedge CLK); #1;
      CMD_VALID = 1'b0;
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      exp_cnt = '0; m_acc = '0;
      chk("mid_rst_cmd_ready", 32'(CMD_READY), 32'd1);
      chk("mid_rst_busy", 32'(BUSY), 32'd0);
      chk("mid_rst_res_valid", 32'(RES_VALID), 32'd0);
      chk("mid_rst_op_cnt", 32'(OP_CNT), 32'd0);
      chk("mid_rst_alu_in1", 32'(ALU_IN1), 32'd0);
      chk("mid_rst_alu_in2", 32'(ALU_IN2), 32'd0);
      chk("mid_rst_alu_op", 32'(ALU_OP), 32'd0);
      repeat (SC + 1) @(posedge CLK);
      #1 chk("mid_rst_no_result", 32'(RES_VALID), 32'd0);

      // randomized operations
      for (int n = 0; n < 30; n++) begin
         rop  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(5, 15))
                                             : 4'($urandom_range(0, 4));
         rin2 = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
         run_op(16'($urandom), rin2, rop, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
